// File: rtl/prog_ram_arbiter.sv
// rtl/prog_ram_arbiter.sv - single RAM port arbiter between 6502 CPU and UART program loader
module prog_ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int RESET_CYCLES = 8
) (
    input  logic              clk_ram,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_write_en,
    input  logic              ld_ask_for_ram,
    input  logic              ld_end_of_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_rdy,
    output logic              cpu_reset,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ld_busy,
    output logic [15:0]       ld_count,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(RESET_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALT_REQ = 2'd1,
        ST_LOAD     = 2'd2,
        ST_REBOOT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               cpu_rdy_q, cpu_rdy_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic [15:0]        ld_count_q, ld_count_d;
    logic               proto_err_q, proto_err_d;
    logic [CNT_W-1:0]   reboot_cnt_q, reboot_cnt_d;

    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cpu_rdy_q    <= 1'b1;
            cpu_reset_q  <= 1'b0;
            ld_count_q   <= 16'd0;
            proto_err_q  <= 1'b0;
            reboot_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cpu_rdy_q    <= cpu_rdy_d;
            cpu_reset_q  <= cpu_reset_d;
            ld_count_q   <= ld_count_d;
            proto_err_q  <= proto_err_d;
            reboot_cnt_q <= reboot_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        reboot_cnt_d = reboot_cnt_q;
        ld_count_d   = ld_count_q;
        // A loader write outside LOAD is dropped at the mux and latched as an error.
        proto_err_d  = proto_err_q | (ld_write_en && (state_q != ST_LOAD));

        case (state_q)
            ST_RUN: begin
                if (ld_ask_for_ram) begin
                    state_d    = ST_HALT_REQ;
                    ld_count_d = 16'd0;
                end
            end
            ST_HALT_REQ: begin
                // RDY is ignored by the 6502 on write cycles, so wait for a read cycle.
                if (!ld_ask_for_ram) begin
                    state_d = ST_RUN;
                end else if (!cpu_we) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_write_en && (ld_count_q != 16'hFFFF)) begin
                    ld_count_d = ld_count_q + 16'd1;
                end
                if (ld_end_of_data) begin
                    state_d      = ST_REBOOT;
                    reboot_cnt_d = CNT_W'(RESET_CYCLES - 1);
                end else if (!ld_ask_for_ram) begin
                    state_d = ST_RUN;
                end
            end
            ST_REBOOT: begin
                if (reboot_cnt_q == '0) begin
                    state_d = ld_ask_for_ram ? ST_HALT_REQ : ST_RUN;
                end else begin
                    reboot_cnt_d = reboot_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        cpu_rdy_d   = !((state_d == ST_HALT_REQ) || (state_d == ST_LOAD));
        cpu_reset_d = (state_d == ST_REBOOT);
    end

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_dout;
        ram_we    = cpu_we;
        case (state_q)
            ST_LOAD: begin
                ram_addr  = ld_waddr;
                ram_wdata = ld_wdata;
                ram_we    = ld_write_en;
            end
            ST_REBOOT: begin
                ram_we = 1'b0;
            end
            default: begin
                ram_we = cpu_we;
            end
        endcase
    end

    assign cpu_din   = ram_rdata;
    assign cpu_rdy   = cpu_rdy_q;
    assign cpu_reset = cpu_reset_q;
    assign ld_busy   = (state_q != ST_RUN);
    assign ld_count  = ld_count_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_prog_ram_arbiter.sv
// tb/tb_prog_ram_arbiter.sv - self-checking bench for prog_ram_arbiter
module tb_prog_ram_arbiter;

    localparam int RC = 8;

    logic        clk_ram = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ld_waddr = '0;
    logic [7:0]  ld_wdata = '0;
    logic        ld_write_en = 1'b0;
    logic        ld_ask_for_ram = 1'b0;
    logic        ld_end_of_data = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        cpu_reset;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        ld_busy;
    logic [15:0] ld_count;
    logic        proto_err;

    logic [7:0]  mem [0:65535];

    int n_total = 0;
    int n_pass  = 0;

    prog_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RESET_CYCLES(RC)) dut (
        .clk_ram(clk_ram), .reset(reset),
        .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_write_en(ld_write_en),
        .ld_ask_for_ram(ld_ask_for_ram), .ld_end_of_data(ld_end_of_data),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .cpu_reset(cpu_reset),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .ld_busy(ld_busy), .ld_count(ld_count),
        .proto_err(proto_err)
    );

    always #5 clk_ram = ~clk_ram;

    always @(posedge clk_ram) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic quiet_inputs();
        ld_write_en = 0; ld_ask_for_ram = 0; ld_end_of_data = 0; cpu_we = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_ram);
        quiet_inputs();
        reset = 0;
        @(negedge clk_ram);
        @(negedge clk_ram);
        reset = 1;
    endtask

    // Count consecutive cycles with cpu_reset high, starting at the current sample point.
    task automatic count_reboot(output int n);
        n = 0;
        while (cpu_reset === 1'b1 && n < 50) begin
            n++;
            @(negedge clk_ram);
            #1;
        end
    endtask

    typedef struct packed {
        logic ask, wen, eod, cwe;
        logic rdy, rst, busy, we, sel_ld;
        logic [15:0] cnt;
        logic perr;
    } vec_t;

    vec_t vecs [12];

    // Reference model: loader session phases with a countdown of remaining reset cycles.
    localparam int PH_RUN = 0, PH_WAIT = 1, PH_LOAD = 2, PH_BOOT = 3;
    int m_phase, m_left, m_cnt;
    bit m_perr;

    initial begin
        int n;
        bit loading;

        // Test 1: reset release, CPU owns the RAM
        repeat (2) @(negedge clk_ram);
        reset = 1;
        @(negedge clk_ram);
        cpu_addr = 16'h0200; cpu_dout = 8'h42; cpu_we = 1;
        #1;
        check("t1_ram_addr", ram_addr, 16'h0200);
        check("t1_ram_wdata", ram_wdata, 8'h42);
        check("t1_ram_we", ram_we, 1);
        check("t1_cpu_rdy", cpu_rdy, 1);
        check("t1_cpu_reset", cpu_reset, 0);
        check("t1_ld_busy", ld_busy, 0);
        check("t1_ld_count", ld_count, 0);
        check("t1_proto_err", proto_err, 0);
        @(negedge clk_ram);
        cpu_we = 0;
        #1;
        check("t1_cpu_din", cpu_din, 8'h42);

        // Tests 2, 4, 5: table of per-cycle vectors
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 16'd0, 1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 16'd0, 1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0, 16'd0, 1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0, 16'd0, 1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0, 16'd0, 1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1, 16'd0, 1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1, 16'd1, 1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1, 16'd1, 1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 16'd1, 1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 16'd1, 1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 16'd1, 1'b1};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 16'd1, 1'b1};
        do_reset();
        cpu_addr = 16'h0300; cpu_dout = 8'h11; ld_waddr = 16'h0700;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_ram);
            ld_ask_for_ram = vecs[i].ask; ld_write_en = vecs[i].wen;
            ld_end_of_data = vecs[i].eod; cpu_we = vecs[i].cwe;
            ld_wdata = 8'h55 + 8'(i);
            #1;
            check($sformatf("v%0d_rdy", i), cpu_rdy, vecs[i].rdy);
            check($sformatf("v%0d_rst", i), cpu_reset, vecs[i].rst);
            check($sformatf("v%0d_busy", i), ld_busy, vecs[i].busy);
            check($sformatf("v%0d_we", i), ram_we, vecs[i].we);
            check($sformatf("v%0d_addr", i), ram_addr, vecs[i].sel_ld ? 16'h0700 : 16'h0300);
            check($sformatf("v%0d_cnt", i), ld_count, vecs[i].cnt);
            check($sformatf("v%0d_perr", i), proto_err, vecs[i].perr);
        end
        check("tbl_mem_0700", mem[16'h0700], 8'h5A);

        // Test 3: three-byte load, last byte together with end_of_data
        do_reset();
        @(negedge clk_ram);
        ld_ask_for_ram = 1; cpu_we = 0;
        @(negedge clk_ram);
        @(negedge clk_ram);
        for (int i = 0; i < 3; i++) begin
            ld_write_en = 1; ld_waddr = 16'h0600 + 16'(i);
            ld_wdata = (i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'hCC;
            ld_end_of_data = (i == 2);
            @(negedge clk_ram);
        end
        quiet_inputs();
        cpu_addr = 16'h0601; cpu_dout = 8'hEE; cpu_we = 1;
        #1;
        check("t3_reboot_we", ram_we, 0);
        check("t3_reboot_rdy", cpu_rdy, 1);
        count_reboot(n);
        check("t3_reset_cycles", n, RC);
        check("t3_rdy", cpu_rdy, 1);
        check("t3_busy", ld_busy, 0);
        check("t3_count", ld_count, 3);
        check("t3_perr", proto_err, 0);
        check("t3_mem0", mem[16'h0600], 8'hAA);
        check("t3_mem1", mem[16'h0601], 8'hBB);
        check("t3_mem2", mem[16'h0602], 8'hCC);
        cpu_we = 0;

        // Test 6: async reset in reboot cycle 4, then ask held through reboot end
        do_reset();
        @(negedge clk_ram);
        ld_ask_for_ram = 1;
        @(negedge clk_ram);
        @(negedge clk_ram);
        ld_end_of_data = 1;
        @(negedge clk_ram);
        ld_end_of_data = 0;
        repeat (3) @(negedge clk_ram);
        #1;
        check("t6_pre_reset", cpu_reset, 1);
        reset = 0;
        #1;
        check("t6_reset_cpu_reset", cpu_reset, 0);
        check("t6_reset_busy", ld_busy, 0);
        check("t6_reset_rdy", cpu_rdy, 1);
        @(negedge clk_ram);
        reset = 1;
        @(negedge clk_ram);
        @(negedge clk_ram);
        ld_end_of_data = 1;
        @(negedge clk_ram);
        ld_end_of_data = 0;
        #1;
        count_reboot(n);
        check("t6_reset_cycles", n, RC);
        check("t6_halt_busy", ld_busy, 1);
        check("t6_halt_rdy", cpu_rdy, 0);
        @(negedge clk_ram);
        #1;
        check("t6_load_busy", ld_busy, 1);
        ld_ask_for_ram = 0;
        @(negedge clk_ram);
        @(negedge clk_ram);
        #1;
        check("t6_run_rdy", cpu_rdy, 1);
        check("t6_run_busy", ld_busy, 0);

        // Randomized run against the reference model
        do_reset();
        m_phase = PH_RUN; m_left = 0; m_cnt = 0; m_perr = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_ram);
            if ($urandom_range(0, 9) == 0) ld_ask_for_ram = ~ld_ask_for_ram;
            ld_write_en    = ($urandom_range(0, 9) < 4);
            ld_end_of_data = ($urandom_range(0, 15) == 0);
            cpu_we         = $urandom_range(0, 1);
            cpu_addr       = 16'($urandom);
            cpu_dout       = 8'($urandom);
            ld_waddr       = 16'($urandom);
            ld_wdata       = 8'($urandom);
            #1;
            loading = (m_phase == PH_LOAD);
            check("r_rdy", cpu_rdy, !(m_phase == PH_WAIT || loading));
            check("r_rst", cpu_reset, m_phase == PH_BOOT);
            check("r_busy", ld_busy, m_phase != PH_RUN);
            check("r_addr", ram_addr, loading ? ld_waddr : cpu_addr);
            check("r_wdata", ram_wdata, loading ? ld_wdata : cpu_dout);
            check("r_we", ram_we, loading ? ld_write_en : (m_phase == PH_BOOT ? 1'b0 : cpu_we));
            check("r_cnt", ld_count, m_cnt);
            check("r_perr", proto_err, m_perr);
            if (ld_write_en && !loading) m_perr = 1;
            if (loading && ld_write_en && m_cnt < 65535) m_cnt++;
            case (m_phase)
                PH_RUN:  if (ld_ask_for_ram) begin m_phase = PH_WAIT; m_cnt = 0; end
                PH_WAIT: if (!ld_ask_for_ram) m_phase = PH_RUN;
                         else if (!cpu_we) m_phase = PH_LOAD;
                PH_LOAD: if (ld_end_of_data) begin m_phase = PH_BOOT; m_left = RC; end
                         else if (!ld_ask_for_ram) m_phase = PH_RUN;
                default: begin
                    m_left--;
                    if (m_left == 0) m_phase = ld_ask_for_ram ? PH_WAIT : PH_RUN;
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
